// File: rtl/conv_pkg.sv
// Shared constants and helpers for the conv window sequencer slice.
package conv_pkg;

   // Default kernel geometry and channel-group depth
   localparam int K_H_DEF    = 3;
   localparam int K_W_DEF    = 3;
   localparam int CH_MAX_DEF = 16;

   // Gap policy: discard the partial window, or pause it until in_vld returns
   localparam bit GAP_DISCARD = 1'b1;
   localparam bit GAP_PAUSE   = 1'b0;

   // Index width for a counter covering 0..n-1, never narrower than one bit
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_idx_cnt.sv
// Single wrap counter: steps on en, returns to zero after reaching max.
// wrap is combinational so counters can be chained through it in one cycle.
module conv_idx_cnt
#(
   parameter int W = 2
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] max,
   output logic [W-1:0] value,
   output logic         wrap
);

   assign wrap = en && (value == max);

   // Count register; clr wins over en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (en) begin
         value <= wrap ? '0 : value + W'(1);
      end
   end

endmodule

// File: rtl/conv_win_seq.sv
// Window sequencer for the conv datapath. Walks each accepted beat over a
// K_H x K_W kernel and a runtime number of channel groups (kc fastest, then
// kr, then ch), flags the first and last tap for the MAC accumulator, and
// hands each completed window downstream through a one-deep out_vld slot.
module conv_win_seq
   import conv_pkg::*;
#(
   parameter int K_H     = K_H_DEF,
   parameter int K_W     = K_W_DEF,
   parameter int CH_MAX  = CH_MAX_DEF,
   parameter bit GAP_CLR = GAP_DISCARD,
   parameter int WCNT_W  = 16,
   localparam int KRW    = clog2_min1(K_H),
   localparam int KCW    = clog2_min1(K_W),
   localparam int CHW    = clog2_min1(CH_MAX),
   localparam int CW     = $clog2(CH_MAX + 1)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic [CW-1:0]     cfg_ch,
   input  logic              in_vld,
   output logic              in_rdy,
   output logic [KRW-1:0]    kr,
   output logic [KCW-1:0]    kc,
   output logic [CHW-1:0]    ch,
   output logic              first,
   output logic              last,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [WCNT_W-1:0] win_cnt,
   output logic              err_gap
);

   logic            acc;
   logic            hs;
   logic            gap;
   logic            gap_clr;
   logic            cnt_clr;
   logic            kc_wrap;
   logic            kr_wrap;
   logic            ch_wrap;
   logic [CW-1:0]   ch_cfg_sat;
   logic [CW-1:0]   ch_lat;
   logic [CW-1:0]   ch_eff;
   logic [CHW-1:0]  ch_top;

   // The slot only blocks input while a completion is waiting and not being taken
   assign in_rdy  = !(out_vld && !out_rdy);
   assign acc     = in_vld && in_rdy;
   assign hs      = out_vld && out_rdy;

   assign first   = (kr == '0) && (kc == '0) && (ch == '0);

   // A gap only matters inside a window; an idle input between windows is normal
   assign gap     = !in_vld && !first;
   assign gap_clr = (GAP_CLR == GAP_DISCARD) && gap;
   assign cnt_clr = clr || gap_clr;

   // Normalise cfg_ch: zero means one group, anything above CH_MAX saturates
   always_comb begin
      ch_cfg_sat = cfg_ch;
      if (cfg_ch == '0) begin
         ch_cfg_sat = CW'(1);
      end else if (cfg_ch > CW'(CH_MAX)) begin
         ch_cfg_sat = CW'(CH_MAX);
      end
   end

   // On tap 0 the live config is used directly so a one-beat window can
   // still flag last; afterwards the value captured at tap 0 is used.
   assign ch_eff = first ? ch_cfg_sat : ch_lat;
   assign ch_top = CHW'(ch_eff - CW'(1));

   assign last   = (kc == KCW'(K_W - 1)) && (kr == KRW'(K_H - 1)) && (ch == ch_top);

   // Capture the channel-group count at the window's first accepted beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_lat <= CW'(1);
      end else if (clr) begin
         ch_lat <= CW'(1);
      end else if (acc && first) begin
         ch_lat <= ch_cfg_sat;
      end
   end

   conv_idx_cnt #(.W(KCW)) u_kc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (acc),
      .max   (KCW'(K_W - 1)),
      .value (kc),
      .wrap  (kc_wrap)
   );

   conv_idx_cnt #(.W(KRW)) u_kr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (kc_wrap),
      .max   (KRW'(K_H - 1)),
      .value (kr),
      .wrap  (kr_wrap)
   );

   conv_idx_cnt #(.W(CHW)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (kr_wrap),
      .max   (ch_top),
      .value (ch),
      .wrap  (ch_wrap)
   );

   // Completion slot: a new completion has priority over a same-cycle handover,
   // so the slot refills rather than dropping for a cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld <= 1'b0;
      end else if (clr) begin
         out_vld <= 1'b0;
      end else if (ch_wrap) begin
         out_vld <= 1'b1;
      end else if (hs) begin
         out_vld <= 1'b0;
      end
   end

   // Count handovers, wrapping naturally at the counter width
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt <= '0;
      end else if (clr) begin
         win_cnt <= '0;
      end else if (hs) begin
         win_cnt <= win_cnt + WCNT_W'(1);
      end
   end

   // Sticky record that a partial window was thrown away
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_gap <= 1'b0;
      end else if (clr) begin
         err_gap <= 1'b0;
      end else if (gap_clr) begin
         err_gap <= 1'b1;
      end
   end

endmodule

// File: tb/tb_conv_win_seq.sv
// Bench for conv_win_seq: scoreboarded beats/completions on the default
// instance, plus directed checks on a pause-mode and a 1x1-kernel instance.
module tb_conv_win_seq;

   typedef struct packed {
      logic [1:0] kr;
      logic [1:0] kc;
      logic [3:0] ch;
      logic       first;
      logic       last;
   } beat_t;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic [4:0]  cfg_ch;
   logic        in_vld;
   logic        in_rdy;
   logic [1:0]  kr;
   logic [1:0]  kc;
   logic [3:0]  ch;
   logic        first;
   logic        last;
   logic        out_vld;
   logic        out_rdy;
   logic [15:0] win_cnt;
   logic        err_gap;

   logic        clr_x;
   logic [4:0]  cfg_ch_x;
   logic        out_rdy_x;

   logic        in_vld_p, in_rdy_p, first_p, last_p, out_vld_p, err_gap_p;
   logic [1:0]  kr_p, kc_p;
   logic [3:0]  ch_p;
   logic [15:0] win_cnt_p;

   logic        in_vld_u, in_rdy_u, first_u, last_u, out_vld_u, err_gap_u;
   logic        kr_u, kc_u;
   logic [3:0]  ch_u;
   logic [15:0] win_cnt_u;

   int          n_tests;
   int          n_fail;
   int          exp_hs;
   beat_t       exp_beat[$];
   int          exp_win[$];

   conv_win_seq dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_ch(cfg_ch),
      .in_vld(in_vld), .in_rdy(in_rdy), .kr(kr), .kc(kc), .ch(ch),
      .first(first), .last(last), .out_vld(out_vld), .out_rdy(out_rdy),
      .win_cnt(win_cnt), .err_gap(err_gap)
   );

   conv_win_seq #(.GAP_CLR(1'b0)) dut_p (
      .clk(clk), .rst_n(rst_n), .clr(clr_x), .cfg_ch(cfg_ch_x),
      .in_vld(in_vld_p), .in_rdy(in_rdy_p), .kr(kr_p), .kc(kc_p), .ch(ch_p),
      .first(first_p), .last(last_p), .out_vld(out_vld_p), .out_rdy(out_rdy_x),
      .win_cnt(win_cnt_p), .err_gap(err_gap_p)
   );

   conv_win_seq #(.K_H(1), .K_W(1)) dut_u (
      .clk(clk), .rst_n(rst_n), .clr(clr_x), .cfg_ch(cfg_ch_x),
      .in_vld(in_vld_u), .in_rdy(in_rdy_u), .kr(kr_u), .kc(kc_u), .ch(ch_u),
      .first(first_u), .last(last_u), .out_vld(out_vld_u), .out_rdy(out_rdy_x),
      .win_cnt(win_cnt_u), .err_gap(err_gap_u)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare each presented accepted beat and each handover
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_vld && in_rdy) begin
            if (exp_beat.size() == 0) begin
               chk("beat_unexpected", 1, 0);
            end else begin
               beat_t e;
               e = exp_beat.pop_front();
               chk("beat_kr", kr, e.kr);
               chk("beat_kc", kc, e.kc);
               chk("beat_ch", ch, e.ch);
               chk("beat_first", first, e.first);
               chk("beat_last", last, e.last);
            end
         end
         if (out_vld && out_rdy) begin
            if (exp_win.size() == 0) begin
               chk("handover_unexpected", 1, 0);
            end else begin
               chk("handover_win_cnt", win_cnt, exp_win.pop_front());
            end
         end
      end
   end

   // Drive nbeats accepted beats of windows with che channel groups
   task automatic run_win(input int nbeats, input int che, input int chg_at, input logic [4:0] chg_val);
      int wsz;
      wsz = 9 * che;
      for (int b = 0; b < nbeats; b++) begin
         beat_t e;
         if (b == chg_at) cfg_ch = chg_val;
         e.kc    = 2'(b % 3);
         e.kr    = 2'((b / 3) % 3);
         e.ch    = 4'((b % wsz) / 9);
         e.first = ((b % wsz) == 0);
         e.last  = ((b % wsz) == wsz - 1);
         exp_beat.push_back(e);
         if (e.last) begin
            exp_win.push_back(exp_hs);
            exp_hs++;
         end
         in_vld = 1'b1;
         @(posedge clk); #1;
         chk("out_vld_after_beat", out_vld, e.last);
      end
   endtask

   task automatic idle(input int n);
      in_vld = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0; n_fail = 0; exp_hs = 0;
      rst_n = 1'b0; clr = 1'b0; cfg_ch = 5'd1; in_vld = 1'b0; out_rdy = 1'b1;
      clr_x = 1'b0; cfg_ch_x = 5'd1; out_rdy_x = 1'b1; in_vld_p = 1'b0; in_vld_u = 1'b0;
      #2;
      chk("rst_kr", kr, 0);
      chk("rst_kc", kc, 0);
      chk("rst_ch", ch, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_win_cnt", win_cnt, 0);
      chk("rst_err_gap", err_gap, 0);
      chk("rst_in_rdy", in_rdy, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: two 3x3 windows, one channel group
      run_win(18, 1, -1, 5'd0);
      idle(1);
      chk("t1_win_cnt", win_cnt, 2);
      chk("t1_err_gap", err_gap, 0);

      // 2: four groups, mid-window cfg change ignored
      cfg_ch = 5'd4;
      run_win(36, 4, 9, 5'd2);
      idle(1);
      chk("t2_win_cnt", win_cnt, 3);

      // 3: backpressure on completion
      cfg_ch = 5'd1;
      out_rdy = 1'b0;
      run_win(9, 1, -1, 5'd0);
      for (int i = 0; i < 5; i++) begin
         chk("t3_in_rdy_stall", in_rdy, 0);
         @(posedge clk); #1;
         chk("t3_out_vld_held", out_vld, 1);
         chk("t3_cnt_zero", {kr, kc, ch}, 0);
         chk("t3_win_cnt_hold", win_cnt, 3);
      end
      in_vld = 1'b0;
      out_rdy = 1'b1;
      #1;
      chk("t3_in_rdy_release", in_rdy, 1);
      @(posedge clk); #1;
      chk("t3_win_cnt", win_cnt, 4);
      chk("t3_out_vld_clear", out_vld, 0);

      // 4a: gap discards partial window
      run_win(5, 1, -1, 5'd0);
      idle(1);
      chk("t4_gap_cnt_zero", {kr, kc, ch}, 0);
      chk("t4_err_gap", err_gap, 1);
      run_win(9, 1, -1, 5'd0);
      idle(1);
      chk("t4_win_cnt", win_cnt, 5);

      // 5a/5b: cfg_ch zero and oversize
      cfg_ch = 5'd0;
      run_win(9, 1, -1, 5'd0);
      idle(1);
      chk("t5_ch0_win_cnt", win_cnt, 6);
      cfg_ch = 5'd20;
      run_win(144, 16, -1, 5'd0);
      idle(1);
      chk("t5_ch20_win_cnt", win_cnt, 7);

      // 5c: clr on the fourth beat
      cfg_ch = 5'd1;
      run_win(3, 1, -1, 5'd0);
      begin
         beat_t e;
         e = '{kr: 2'd1, kc: 2'd0, ch: 4'd0, first: 1'b0, last: 1'b0};
         exp_beat.push_back(e);
      end
      clr = 1'b1;
      in_vld = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      in_vld = 1'b0;
      exp_hs = 0;
      chk("t5_clr_cnt", {kr, kc, ch}, 0);
      chk("t5_clr_out_vld", out_vld, 0);
      chk("t5_clr_win_cnt", win_cnt, 0);
      chk("t5_clr_err_gap", err_gap, 0);
      idle(1);
      chk("t5_clr_no_out_vld", out_vld, 0);

      // 6: async reset mid-window
      run_win(9, 1, -1, 5'd0);
      idle(1);
      chk("t6_pre_win_cnt", win_cnt, 1);
      run_win(4, 1, -1, 5'd0);
      in_vld = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_cnt", {kr, kc, ch}, 0);
      chk("t6_rst_win_cnt", win_cnt, 0);
      chk("t6_rst_out_vld", out_vld, 0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      exp_hs = 0;
      run_win(9, 1, -1, 5'd0);
      idle(1);
      chk("t6_win_cnt", win_cnt, 1);

      // 4b: pause mode holds counters across a gap
      in_vld_p = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      in_vld_p = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t4p_kr_hold", kr_p, 1);
      chk("t4p_kc_hold", kc_p, 2);
      chk("t4p_err_gap", err_gap_p, 0);
      in_vld_p = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t4p_last", last_p, 1);
      @(posedge clk); #1;
      chk("t4p_out_vld", out_vld_p, 1);
      in_vld_p = 1'b0;
      @(posedge clk); #1;
      chk("t4p_win_cnt", win_cnt_p, 1);

      // 5d: 1x1 kernel, completion coincides with handover every cycle
      in_vld_u = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         chk("t5u_first", first_u, 1);
         chk("t5u_last", last_u, 1);
         @(posedge clk); #1;
         chk("t5u_out_vld", out_vld_u, 1);
         chk("t5u_win_cnt", win_cnt_u, k - 1);
      end
      in_vld_u = 1'b0;
      @(posedge clk); #1;
      chk("t5u_final_win_cnt", win_cnt_u, 5);
      chk("t5u_final_out_vld", out_vld_u, 0);

      chk("beat_queue_empty", exp_beat.size(), 0);
      chk("win_queue_empty", exp_win.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_win_seq.md
Name: conv_win_seq

Overview:
Parametrised window sequencer for the conv datapath. It counts accepted input beats over a K_H x K_W kernel and a runtime number of input-channel groups. For each beat it reports the tap indices (kr, kc, ch) plus first/last flags for the MAC accumulator. When a window completes it raises a registered out_vld, held under an out_rdy handshake, and it applies a selectable policy for gaps in in_vld.

Parameters:
K_H, 3, kernel rows (>=1)
K_W, 3, kernel columns (>=1)
CH_MAX, 16, maximum input-channel groups per window (>=1)
GAP_CLR, 1, 1 = a gap in in_vld discards the partial window; 0 = a gap pauses the window
WCNT_W, 16, width of the completed-window counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
clr  in  1  synchronous abort/clear
cfg_ch  in  $clog2(CH_MAX+1)  channel groups per window; sampled at the window's first beat
in_vld  in  1  input beat valid
in_rdy  out  1  input beat ready
kr  out  $clog2(K_H) (min 1)  row index of the presented beat
kc  out  $clog2(K_W) (min 1)  column index of the presented beat
ch  out  $clog2(CH_MAX) (min 1)  channel-group index of the presented beat
first  out  1  presented beat is tap 0 of the window
last  out  1  presented beat completes the window
out_vld  out  1  window complete
out_rdy  in  1  downstream accepts completion
win_cnt  out  WCNT_W  number of completions handed over, wraps modulo 2^WCNT_W
err_gap  out  1  sticky: a partial window was discarded (GAP_CLR=1 only)

Behaviour:
- Reset (rst_n low): kr, kc, ch, out_vld, win_cnt, err_gap = 0; latched channel count = 1.
- Accept: acc = in_vld && in_rdy.
- Ready: in_rdy = !(out_vld && !out_rdy). This is a one-deep completion slot; in_rdy is combinational.
- Counter order: kc is fastest, then kr, then ch. On acc:
  - kc wraps at K_W-1 and carries into kr.
  - kr wraps at K_H-1 and carries into ch.
  - ch wraps at ch_eff-1, which returns all counters to 0.
- Effective channel count ch_eff:
  - At the window's first beat, ch_eff = cfg_ch, with cfg_ch=0 treated as 1 and cfg_ch>CH_MAX clamped to CH_MAX.
  - That value is latched at the first beat and used for the rest of the window.
  - cfg_ch changes mid-window are ignored.
- Flags (combinational from counters and ch_eff, valid whenever in_vld):
  - first = (kr==0 && kc==0 && ch==0).
  - last = (kc==K_W-1 && kr==K_H-1 && ch==ch_eff-1).
  - If K_H=K_W=ch_eff=1, first and last are both 1.
- out_vld is set the cycle after an accepted last beat (latency 1). It holds until out_vld && out_rdy.
- Simultaneous completion and handover: if an accepted last beat coincides with an out handshake, out_vld stays 1. The new completion replaces the old one and win_cnt increments once.
- win_cnt increments on each out handshake and wraps.
- Gap: in_vld=0 while any counter is non-zero.
  - GAP_CLR=1: counters clear to 0 on the next edge and err_gap sets.
  - GAP_CLR=0: counters hold.
  - in_vld=1 with in_rdy=0 is a stall, not a gap; counters hold in both modes.
- clr: on the next edge, counters, out_vld, win_cnt and err_gap clear to 0. clr dominates a same-cycle acceptance or handshake, and in_rdy stays combinationally as defined.
- Reset mid-window: immediate asynchronous clear. No completion is generated for the partial window.

Decomposition:
- Package conv_pkg:
  - default K_H, K_W, CH_MAX;
  - a clog2-with-minimum-1 width function;
  - GAP_CLR mode constants (GAP_DISCARD=1, GAP_PAUSE=0).
- Sub-module conv_idx_cnt: one wrap counter with inputs en, clr, max and outputs value, wrap. Instantiate it three times (kc, kr, ch), chaining wrap into the next counter's en.

Test Plan:
1. K=3x3, cfg_ch=1, in_vld=1 for 18 cycles, out_rdy=1 -> kc runs 0,1,2,0,…; out_vld pulses one cycle after beats 9 and 18; win_cnt=2; err_gap=0.
2. cfg_ch=4, 36 beats -> first only on beat 1; last only on beat 36 with (ch,kr,kc)=(3,2,2); cfg_ch changed to 2 at beat 10 has no effect; one out_vld.
3. Backpressure: out_rdy=0 when window completes -> out_vld held, in_rdy=0, counters stay 0, win_cnt unchanged. Raise out_rdy after 5 cycles -> handshake, win_cnt+1, in_rdy=1 in that cycle.
4. Gap after 5 beats:
   - GAP_CLR=1 -> counters 0 next cycle, err_gap=1; 9 further beats give exactly one out_vld.
   - GAP_CLR=0 -> counters hold at (kr,kc)=(1,2); 4 further beats give out_vld.
5. Config edge cases:
   - cfg_ch=0 -> window completes in 9 beats.
   - cfg_ch=20 with CH_MAX=16 -> window completes in 144 beats.
   - clr on beat 4 -> all state 0, no out_vld.
   - Last beat with out_rdy=1 and out_vld=1 -> out_vld stays 1, win_cnt+1.
6. Async reset: rst_n pulsed low mid-window between clock edges -> outputs 0 immediately; next 9 beats give a normal completion.
